hazard_tracker: RTL

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_tracker.sv
// Tracks destination/write-back info through ID/EX, EX/MEM and MEM/WB, detects
// load-use hazards, and freezes or bubbles the pipeline as required.
module hazard_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_wr_add,
    input  logic       id_wb,
    input  logic       id_mem_read,
    input  logic [2:0] id_src_add,
    input  logic [2:0] id_dst_add,
    input  logic       id_src_used,
    input  logic       id_dst_used,
    input  logic       mem_busy,
    input  logic       flush,
    output logic [2:0] wr_add_alu,
    output logic       wb_alu,
    output logic [2:0] wr_add_mem,
    output logic       wb_mem,
    output logic       stall,
    output logic [7:0] stall_cnt,
    output logic [1:0] state
);

    typedef struct packed {
        logic       valid;
        logic [2:0] wr_add;
        logic       wb;
        logic       mem_read;
    } stage_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_MEMWAIT = 2'b10
    } state_t;

    localparam stage_t BUBBLE = '{valid: 1'b0, wr_add: 3'd0, wb: 1'b0, mem_read: 1'b0};

    stage_t s1_r, s2_r, s3_r;
    stage_t id_stage_s;
    state_t state_r, state_nx_s;
    logic   load_use_s;
    logic   stall_s;
    logic [7:0] stall_cnt_r;

    // Hazard detection and stall request; reset suppresses any stall.
    always_comb begin
        id_stage_s = '{valid: id_valid, wr_add: id_wr_add,
                       wb: id_wb & id_valid, mem_read: id_mem_read & id_valid};
        load_use_s = 1'b0;
        if (s1_r.valid && s1_r.mem_read && s1_r.wb && id_valid) begin
            load_use_s = (id_src_used && (id_src_add == s1_r.wr_add)) ||
                         (id_dst_used && (id_dst_add == s1_r.wr_add));
        end else begin
            load_use_s = 1'b0;
        end
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            stall_s = mem_busy | (load_use_s & ~flush);
        end
    end

    // Stage registers: freeze on mem_busy, bubble S1 on flush or load-use.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= BUBBLE;
            s2_r <= BUBBLE;
            s3_r <= BUBBLE;
        end else if (mem_busy) begin
            s1_r <= s1_r;
            s2_r <= s2_r;
            s3_r <= s3_r;
        end else begin
            s3_r <= s2_r;
            s2_r <= s1_r;
            if (flush || load_use_s) begin
                s1_r <= BUBBLE;
            end else begin
                s1_r <= id_stage_s;
            end
        end
    end

    // FSM next state; MEMWAIT takes precedence, flush cancels a load-use stall.
    always_comb begin
        state_nx_s = ST_RUN;
        case (state_r)
            ST_RUN, ST_LDSTALL, ST_MEMWAIT: begin
                if (mem_busy) begin
                    state_nx_s = ST_MEMWAIT;
                end else if (load_use_s && !flush) begin
                    state_nx_s = ST_LDSTALL;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 8'd0;
        end else if (stall_s && (stall_cnt_r != 8'd255)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // wb fields are zero in any invalid stage, so outputs come straight from flops.
    assign wr_add_alu = s2_r.wr_add;
    assign wb_alu     = s2_r.wb;
    assign wr_add_mem = s3_r.wr_add;
    assign wb_mem     = s3_r.wb;
    assign stall      = stall_s;
    assign stall_cnt  = stall_cnt_r;
    assign state      = state_r;

endmodule
